// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the simple CPU control unit, datapath and bench.
// State encoding, opcode constants and ALU operation encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH1 = 4'd1,
    ST_FETCH2 = 4'd2,
    ST_FETCH3 = 4'd3,
    ST_DECODE = 4'd4,
    ST_EX_RD  = 4'd5,
    ST_EX_ACC = 4'd6,
    ST_EX_WR  = 4'd7,
    ST_EX_JMP = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_LOAD  = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h04;
  localparam logic [7:0] OP_JUMP  = 8'h05;
  localparam logic [7:0] OP_JUMPZ = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_OR  = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier for the control unit.
// Optional feature macro: CTRL_HALT_EN (when undefined, 0xFF is not a HALT
// and is_halt is tied to 0, so 0xFF falls through as a NOP).
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_or,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_jmp,
  output logic       o_is_jmpz,
  output logic       o_is_halt
);

  assign o_is_alu   = (i_opcode == OP_ADD) || (i_opcode == OP_OR);
  assign o_is_or    = (i_opcode == OP_OR);
  assign o_is_load  = (i_opcode == OP_LOAD);
  assign o_is_store = (i_opcode == OP_STORE);
  assign o_is_jmp   = (i_opcode == OP_JUMP);
  assign o_is_jmpz  = (i_opcode == OP_JUMPZ);

`ifdef CTRL_HALT_EN
  assign o_is_halt  = (i_opcode == OP_HALT);
`else
  assign o_is_halt  = 1'b0;
`endif

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM driving the simple CPU datapath strobes.
// Optional feature macro: CTRL_HALT_EN (builds the HALT state for opcode 0xFF).
// o_dbg_state exposes the registered state for checkers.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  input  logic       zflag,
  output logic       muxPC,
  output logic       muxMAR,
  output logic       muxACC,
  output logic       loadPC,
  output logic       loadMAR,
  output logic       loadMDR,
  output logic       loadIR,
  output logic       loadACC,
  output logic       opALU,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] o_dbg_state
);

  state_t r_state;
  state_t w_next_state;

  logic w_is_alu;
  logic w_is_or;
  logic w_is_load;
  logic w_is_store;
  logic w_is_jmp;
  logic w_is_jmpz;
  logic w_is_halt;

  ctrl_decode u_decode (
    .i_opcode   (opcode),
    .o_is_alu   (w_is_alu),
    .o_is_or    (w_is_or),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_is_jmp   (w_is_jmp),
    .o_is_jmpz  (w_is_jmpz),
    .o_is_halt  (w_is_halt)
  );

  assign o_dbg_state = r_state;

  // State register: asynchronous reset forces RST so no strobe survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RST;
    else     r_state <= w_next_state;
  end

  // Next-state and strobe decode; every strobe defaults to 0 and unencoded
  // states fall back to RST.
  always_comb begin
    muxPC        = 1'b0;
    muxMAR       = 1'b0;
    muxACC       = 1'b0;
    loadPC       = 1'b0;
    loadMAR      = 1'b0;
    loadMDR      = 1'b0;
    loadIR       = 1'b0;
    loadACC      = 1'b0;
    opALU        = ALU_ADD;
    MemWrite     = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    w_next_state = ST_RST;
    case (r_state)
      ST_RST: w_next_state = ST_FETCH1;
      ST_FETCH1: begin
        loadMAR      = 1'b1;
        loadPC       = 1'b1;
        w_next_state = ST_FETCH2;
      end
      ST_FETCH2: begin
        loadMDR      = 1'b1;
        w_next_state = ST_FETCH3;
      end
      ST_FETCH3: begin
        loadIR       = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        loadMAR = 1'b1;
        muxMAR  = 1'b1;
        if (w_is_alu || w_is_load)      w_next_state = ST_EX_RD;
        else if (w_is_store)            w_next_state = ST_EX_WR;
        else if (w_is_jmp || w_is_jmpz) w_next_state = ST_EX_JMP;
        else if (w_is_halt)             w_next_state = ST_HALT;
        else begin
          // Unrecognised opcode: NOP completes here.
          instr_done   = 1'b1;
          w_next_state = ST_FETCH1;
        end
      end
      ST_EX_RD: begin
        loadMDR      = 1'b1;
        w_next_state = ST_EX_ACC;
      end
      ST_EX_ACC: begin
        loadACC      = 1'b1;
        muxACC       = w_is_load;
        opALU        = w_is_or ? ALU_OR : ALU_ADD;
        instr_done   = 1'b1;
        w_next_state = ST_FETCH1;
      end
      ST_EX_WR: begin
        MemWrite     = 1'b1;
        instr_done   = 1'b1;
        w_next_state = ST_FETCH1;
      end
      ST_EX_JMP: begin
        // PC already advanced in FETCH1, so a not-taken JUMPZ does nothing.
        if (w_is_jmp || (w_is_jmpz && zflag)) begin
          loadPC = 1'b1;
          muxPC  = 1'b1;
        end
        instr_done   = 1'b1;
        w_next_state = ST_FETCH1;
      end
`ifdef CTRL_HALT_EN
      ST_HALT: begin
        halted       = 1'b1;
        w_next_state = ST_HALT;
      end
`endif
      default: w_next_state = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit with a behavioural datapath
// and memory model; instr_done completion cycles are checked by a scoreboard.
module tb_control_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] opcode;
  logic       zflag;
  logic muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC;
  logic opALU, MemWrite, instr_done, halted;
  logic [3:0] dbg_state;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zflag      (zflag),
    .muxPC      (muxPC),
    .muxMAR     (muxMAR),
    .muxACC     (muxACC),
    .loadPC     (loadPC),
    .loadMAR    (loadMAR),
    .loadMDR    (loadMDR),
    .loadIR     (loadIR),
    .loadACC    (loadACC),
    .opALU      (opALU),
    .MemWrite   (MemWrite),
    .instr_done (instr_done),
    .halted     (halted),
    .o_dbg_state(dbg_state)
  );

  logic [11:0] outs;
  assign outs = {muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR,
                 loadACC, opALU, MemWrite, instr_done, halted};

  // ---------------- datapath / memory model ----------------
  logic [7:0]  pc, mar;
  logic [15:0] mdr, ir, acc;
  logic [15:0] mem [256];
  logic [15:0] mem_init [256];
  logic        acc_preset_en = 1'b0;
  logic [15:0] acc_preset = 16'd0;
  logic        mem_preset_en = 1'b0;

  assign opcode = ir[7:0];
  assign zflag  = (acc == 16'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 8'd0;
      mar <= 8'd0;
      mdr <= 16'd0;
      ir  <= 16'd0;
      if (acc_preset_en) acc <= acc_preset;
      if (mem_preset_en) for (int i = 0; i < 256; i++) mem[i] <= mem_init[i];
    end else begin
      if (loadPC)  pc  <= muxPC ? ir[15:8] : pc + 8'd1;
      if (loadMAR) mar <= muxMAR ? ir[15:8] : pc;
      if (loadMDR) mdr <= mem[mar];
      if (loadIR)  ir  <= mdr;
      if (loadACC) acc <= muxACC ? mdr : (opALU ? (acc | mdr) : (acc + mdr));
      if (MemWrite) mem[mar] <= acc;
    end
  end

  // cycle number since reset release: FETCH1 of the first instruction is cycle 1
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each instr_done pulse pops the expected completion cycle.
  always @(negedge clk) begin
    if (mon_en && !rst && instr_done) begin
      if (exp_q.size() == 0) chk("unexpected_instr_done", 32'(cyc), 32'hFFFF_FFFF);
      else                   chk("instr_done_cycle", 32'(cyc), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_init[i] = 16'd0;
  endtask

  // Hold reset 3 cycles (outputs must be all 0), preload model, release at a negedge.
  task automatic do_reset(input logic load_acc, input logic [15:0] acc_val);
    @(negedge clk);
    acc_preset_en = load_acc;
    acc_preset    = acc_val;
    mem_preset_en = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("outs_in_reset", 32'(outs), 32'd0);
    end
    rst = 1'b0;
  endtask

  // Advance to the negedge of cycle n, bounded.
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cycle_reached", 32'(cyc), 32'(n));
  endtask

  // Close a scoreboard window: every expected pulse must have been seen.
  task automatic end_phase(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic seen;

  initial begin
    // LOAD 0x10, ADD 0x11, STORE 0x12
    clear_mem();
    mem_init[0] = 16'h1003; mem_init[1] = 16'h1101; mem_init[2] = 16'h1204;
    mem_init[8'h10] = 16'd5; mem_init[8'h11] = 16'd7;
    mon_en = 1'b1;
    exp_q.push_back(16'd6); exp_q.push_back(16'd12); exp_q.push_back(16'd17);
    do_reset(1'b1, 16'd0);
    wait_cyc(1);
    chk("fetch1_strobes", 32'({loadMAR, loadPC, muxPC, muxMAR}), 32'b1100);
    chk("fetch1_state", 32'(dbg_state), 32'(ST_FETCH1));
    wait_cyc(6);
    chk("load_muxACC", 32'({loadACC, muxACC}), 32'b11);
    wait_cyc(18);
    chk("store_mem12", 32'(mem[8'h12]), 32'd12);
    chk("acc_after_add", 32'(acc), 32'd12);
    end_phase("seq_all_done_seen");

    // JUMPZ taken: ACC=0
    clear_mem();
    mem_init[0] = 16'h2006;
    mon_en = 1'b1;
    exp_q.push_back(16'd5);
    do_reset(1'b1, 16'd0);
    wait_cyc(5);
    chk("jmpz_taken_strobes", 32'({loadPC, muxPC}), 32'b11);
    wait_cyc(6);
    chk("jmpz_taken_pc", 32'(pc), 32'h20);
    end_phase("jmpz_taken_done_seen");

    // JUMPZ not taken: ACC=3
    mon_en = 1'b1;
    exp_q.push_back(16'd5);
    do_reset(1'b1, 16'd3);
    wait_cyc(5);
    chk("jmpz_nt_strobes", 32'({loadPC, muxPC}), 32'b00);
    wait_cyc(6);
    chk("jmpz_nt_pc", 32'(pc), 32'h01);
    end_phase("jmpz_nt_done_seen");

    // OR: ACC=0x00F0 | mem[0x11]=0x000F
    clear_mem();
    mem_init[0] = 16'h1102; mem_init[8'h11] = 16'h000F;
    mon_en = 1'b1;
    exp_q.push_back(16'd6);
    do_reset(1'b1, 16'h00F0);
    wait_cyc(6);
    chk("or_ex_acc", 32'({loadACC, muxACC, opALU}), 32'b101);
    wait_cyc(7);
    chk("or_result", 32'(acc), 32'h00FF);
    end_phase("or_done_seen");

    // NOP 0x7E: 4 cycles, no loadACC / MemWrite
    clear_mem();
    mem_init[0] = 16'h007E; mem_init[1] = 16'h007E;
    mon_en = 1'b1;
    exp_q.push_back(16'd4);
    do_reset(1'b1, 16'h1234);
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(k);
      seen = seen | loadACC | MemWrite;
    end
    chk("nop_no_acc_or_write", 32'(seen), 32'd0);
    wait_cyc(5);
    chk("nop_back_to_fetch1", 32'(dbg_state), 32'(ST_FETCH1));
    chk("nop_acc_kept", 32'(acc), 32'h1234);
    end_phase("nop_done_seen");

    // 0xFF: HALT when enabled, NOP otherwise
    clear_mem();
    mem_init[0] = 16'h00FF; mem_init[1] = 16'h00FF;
`ifdef CTRL_HALT_EN
    mon_en = 1'b1;
    do_reset(1'b1, 16'd0);
    wait_cyc(4);
    for (int k = 5; k < 25; k++) begin
      wait_cyc(k);
      chk("halt_outs", 32'(outs), 32'h001);
    end
    end_phase("halt_no_done");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("halt_rst_state", 32'(dbg_state), 32'(ST_RST));
    chk("halt_rst_outs", 32'(outs), 32'd0);
`else
    mon_en = 1'b1;
    exp_q.push_back(16'd4);
    do_reset(1'b1, 16'd0);
    wait_cyc(4);
    chk("ff_nop_halted", 32'(halted), 32'd0);
    wait_cyc(5);
    chk("ff_nop_fetch1", 32'(dbg_state), 32'(ST_FETCH1));
    end_phase("ff_nop_done_seen");
`endif

    // Mid-instruction reset during EX_RD of ADD
    clear_mem();
    mem_init[0] = 16'h1101; mem_init[8'h11] = 16'd7;
    do_reset(1'b1, 16'd9);
    wait_cyc(5);
    chk("midrst_in_ex_rd", 32'(dbg_state), 32'(ST_EX_RD));
    acc_preset_en = 1'b0;
    mem_preset_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_outs_zero", 32'(outs), 32'd0);
    chk("midrst_state_rst", 32'(dbg_state), 32'(ST_RST));
    repeat (3) @(negedge clk);
    chk("midrst_acc_unchanged", 32'(acc), 32'd9);
    rst = 1'b0;
    wait_cyc(2);
    chk("midrst_pc_restart", 32'(pc), 32'd1);
    chk("midrst_mar_from_pc0", 32'(mar), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
